imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder on the fetch-side memory port. It accepts halfword read requests (`read_enable`, `address`) from the instruction fetch stage and returns the 16-bit instruction. It drives `stall_memory` while a backing 32-bit synchronous SRAM access is in flight. A one-word line buffer answers repeat requests to the same 32-bit word with no stall, since the two halfword instructions in a word are fetched back-to-back.

## Interface
- `WAIT_STATES`, default 2: extra SRAM cycles after the access cycle. Legal range 0..15.
- `RESET_INSTR`, default 16'h1C00: NOP encoding presented on `instruction_out` after reset.
- `clk` input 1: clock. All state updates on the rising edge.
- `reset` input 1: reset, asynchronous, active-high.
- `read_enable` input 1: fetch read request.
- `address` input 12: byte address.
  - `address[11:2]` selects the word.
  - `address[1]` selects the halfword; 1 selects the upper halfword.
  - `address[0]` is ignored.
- `invalidate` input 1: clears the line buffer. Used by the program loader after instruction-memory writes.
- `instruction_out` output 16: returned instruction. Drives the fetch stage `instruction_in`.
- `stall_memory` output 1: responder busy. The fetch stage must hold its request.
- `sram_ce` output 1: SRAM read strobe. One-cycle pulse.
- `sram_addr` output 10: SRAM word address.
- `sram_rdata` input 32: SRAM read data. Valid `WAIT_STATES+1` cycles after the edge that asserts `sram_ce`.
- `perf_hits` output 16: saturating count of buffer hits.
- `perf_misses` output 16: saturating count of SRAM fills.

## Operation
- All outputs are registered.
- Reset values:
  - state IDLE
  - `stall_memory` 0, `sram_ce` 0, `sram_addr` 0
  - `instruction_out` = `RESET_INSTR`
  - buffer valid 0, tag 0, data 0
  - `perf_hits` 0, `perf_misses` 0
  - wait counter 0
- State IDLE, with `read_enable` low: hold all outputs. `instruction_out` keeps its last value.
- State IDLE, with `read_enable` high and a hit (valid=1 and tag == `address[11:2]`):
  - `instruction_out` <= data[31:16] when `address[1]`=1, else data[15:0].
  - `perf_hits` increments, saturating at 16'hFFFF.
  - Stay in IDLE.
- State IDLE, with `read_enable` high and a miss:
  - Latch `address[1]` into the halfword select.
  - `sram_addr` <= `address[11:2]`; `sram_ce` <= 1.
  - Counter <= `WAIT_STATES`; `stall_memory` <= 1.
  - `perf_misses` increments, saturating.
  - Go to ACCESS.
- State ACCESS:
  - `sram_ce` <= 0. The strobe lasts exactly one cycle.
  - `read_enable` and `address` are ignored. No request is queued.
  - While counter != 0: decrement the counter.
  - When counter == 0, fill:
    - buffer data <= `sram_rdata`; tag <= `sram_addr`; valid <= 1.
    - `instruction_out` <= the selected halfword of `sram_rdata`.
    - `stall_memory` <= 0.
    - Go to IDLE.
- `invalidate` acts in any state. On the edge where it is sampled high, valid <= 0.
- `invalidate` coincident with a fill: invalidate wins, so valid ends at 0. `instruction_out` still receives the fetched halfword, and the fill completes normally.
- `invalidate` coincident with an IDLE request: the lookup uses the pre-edge valid. A hit on that edge is served; valid is 0 afterwards.
- Reset asserted mid-ACCESS: the state, SRAM strobe and stall clear immediately. The in-flight read data is discarded. Counters return to 0.
- Unused state encodings recover to IDLE with `stall_memory` 0.

## Timing
- Hit latency: request sampled at edge E. `instruction_out` is valid after E. `stall_memory` stays 0.
- A request is accepted on every edge in IDLE, so hits sustain one instruction per cycle.
- Miss latency: request sampled at edge E0.
  - `sram_ce` is high for the cycle E0..E0+1.
  - `stall_memory` is high from E0 to E0+`WAIT_STATES`+1, which is `WAIT_STATES`+1 cycles.
  - Data is captured, and `stall_memory` falls, at edge E0+`WAIT_STATES`+1.
- `WAIT_STATES`=0: ACCESS lasts one cycle, so `stall_memory` is high for one cycle.
- Back-to-back request on the edge where `stall_memory` falls: it is not accepted, because the state is still ACCESS. It is accepted on the next edge in IDLE.
- Handshake contract: the fetch stage samples `instruction_out` on the first edge after `stall_memory` falls, and holds `read_enable`/`address` while `stall_memory` is 1.

## Test plan
- Reset release, then idle: `instruction_out`=16'h1C00, `stall_memory`=0, `sram_ce`=0, both perf counters=0.
- `WAIT_STATES`=2, SRAM word 0x040 = 32'hABCD_1234:
  - Step: request address 12'h100. Response: `sram_ce` pulses once with `sram_addr`=10'h040; `stall_memory` high 3 cycles; `instruction_out`=16'h1234; `perf_misses`=1.
  - Step: request 12'h102 immediately after. Response: `instruction_out`=16'hABCD on the next edge, no stall, no `sram_ce`; `perf_hits`=1.
- `invalidate` pulsed the same cycle as a fill of 12'h100, then request 12'h100 again: the first request still returns 16'h1234; the second request misses (`sram_ce` pulses again, `perf_misses`=2).
- `read_enable` toggling with changing addresses during ACCESS: no second `sram_ce`; the returned halfword corresponds to the original address only.
- Reset asserted during the second stall cycle of a miss: `stall_memory`=0 and `instruction_out`=16'h1C00 immediately; the next request to the same address misses.
- Preload `perf_hits` to 16'hFFFE via a force, then issue 3 hits: `perf_hits` reads 16'hFFFF and holds there.

Source files
------------

// File: rtl/imem_responder.sv
// imem_responder: halfword instruction fetch port backed by a 32-bit synchronous SRAM.
// A one-word line buffer serves the second halfword of a word without stalling.
module imem_responder #(
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] RESET_INSTR = 16'h1C00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_enable,
    input  logic [11:0] address,
    input  logic        invalidate,
    output logic [15:0] instruction_out,
    output logic        stall_memory,
    output logic        sram_ce,
    output logic [9:0]  sram_addr,
    input  logic [31:0] sram_rdata,
    output logic [15:0] perf_hits,
    output logic [15:0] perf_misses
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1} state_t;

    state_t      state, state_n;
    logic        valid, valid_n, hsel, hsel_n, stall_n, ce_n;
    logic [9:0]  tag, tag_n, saddr_n;
    logic [31:0] data, data_n;
    logic [3:0]  cnt, cnt_n;
    logic [15:0] instr_n, hits_n, misses_n;
    logic        hit;

    assign hit = valid && tag == address[11:2];

    always_comb begin
        state_n  = state;
        valid_n  = valid;
        hsel_n   = hsel;
        tag_n    = tag;
        data_n   = data;
        cnt_n    = cnt;
        instr_n  = instruction_out;
        stall_n  = stall_memory;
        ce_n     = sram_ce;
        saddr_n  = sram_addr;
        hits_n   = perf_hits;
        misses_n = perf_misses;
        case (state)
            IDLE: begin
                if (read_enable && hit) begin
                    instr_n = address[1] ? data[31:16] : data[15:0];
                    hits_n  = perf_hits + 16'(perf_hits != 16'hFFFF);
                end else if (read_enable) begin
                    hsel_n   = address[1];
                    saddr_n  = address[11:2];
                    ce_n     = 1'b1;
                    cnt_n    = 4'(WAIT_STATES);
                    stall_n  = 1'b1;
                    misses_n = perf_misses + 16'(perf_misses != 16'hFFFF);
                    state_n  = ACCESS;
                end
            end
            ACCESS: begin
                ce_n = 1'b0;
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    data_n  = sram_rdata;
                    tag_n   = sram_addr;
                    valid_n = 1'b1;
                    instr_n = hsel ? sram_rdata[31:16] : sram_rdata[15:0];
                    stall_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                ce_n    = 1'b0;
                stall_n = 1'b0;
                state_n = IDLE;
            end
        endcase
        // Invalidate overrides any fill landing on the same edge.
        if (invalidate) valid_n = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            valid           <= 1'b0;
            hsel            <= 1'b0;
            tag             <= '0;
            data            <= '0;
            cnt             <= '0;
            instruction_out <= RESET_INSTR;
            stall_memory    <= 1'b0;
            sram_ce         <= 1'b0;
            sram_addr       <= '0;
            perf_hits       <= '0;
            perf_misses     <= '0;
        end else begin
            state           <= state_n;
            valid           <= valid_n;
            hsel            <= hsel_n;
            tag             <= tag_n;
            data            <= data_n;
            cnt             <= cnt_n;
            instruction_out <= instr_n;
            stall_memory    <= stall_n;
            sram_ce         <= ce_n;
            sram_addr       <= saddr_n;
            perf_hits       <= hits_n;
            perf_misses     <= misses_n;
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed vectors and miss sequences against a latency-accurate SRAM model.
module tb_imem_responder;
    localparam int WS = 2;

    logic        clk = 1'b0, reset = 1'b1, read_enable = 1'b0, invalidate = 1'b0;
    logic [11:0] address = '0;
    logic [15:0] instruction_out, perf_hits, perf_misses;
    logic        stall_memory, sram_ce;
    logic [9:0]  sram_addr;
    logic [31:0] sram_rdata;
    int          checks = 0, failures = 0;

    imem_responder #(.WAIT_STATES(WS), .RESET_INSTR(16'h1C00)) dut (
        .clk(clk), .reset(reset), .read_enable(read_enable), .address(address),
        .invalidate(invalidate), .instruction_out(instruction_out),
        .stall_memory(stall_memory), .sram_ce(sram_ce), .sram_addr(sram_addr),
        .sram_rdata(sram_rdata), .perf_hits(perf_hits), .perf_misses(perf_misses)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [9:0] a);
        return a == 10'h040 ? 32'hABCD_1234 : {6'h2A, a, 6'h15, a};
    endfunction

    // Read data is only driven during the single cycle it is specified valid.
    logic       pending = 1'b0;
    int         lat = 0;
    logic [9:0] addr_l = '0;
    always @(negedge clk) begin
        if (sram_ce) begin
            pending <= 1'b1;
            lat     <= WS;
            addr_l  <= sram_addr;
        end else if (pending && lat != 0) lat <= lat - 1;
        else pending <= 1'b0;
    end
    assign sram_rdata = (pending && lat == 0) ? mem(addr_l) : 32'hDEAD_BEEF;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic miss(input logic [11:0] a, input bit inv_fill, input bit toggle,
                        input logic [15:0] exp_instr, input logic [15:0] exp_miss);
        int stalls = 0, ces = 0;
        read_enable = 1'b1;
        address = a;
        step();
        check("miss_ce", 32'(sram_ce), 32'd1);
        check("miss_addr", 32'(sram_addr), 32'(a[11:2]));
        while (stall_memory && stalls < 20) begin
            stalls++;
            if (sram_ce) ces++;
            if (toggle) begin
                read_enable = stalls[0];
                address = stalls[0] ? 12'h100 : 12'h7FC;
            end
            if (inv_fill && stalls == WS + 1) invalidate = 1'b1;
            step();
            invalidate = 1'b0;
        end
        read_enable = 1'b0;
        check("miss_stall_cycles", 32'(stalls), 32'(WS + 1));
        check("miss_ce_pulses", 32'(ces), 32'd1);
        check("miss_ce_after", 32'(sram_ce), 32'd0);
        check("miss_instr", 32'(instruction_out), 32'(exp_instr));
        check("miss_count", 32'(perf_misses), 32'(exp_miss));
    endtask

    typedef struct {
        logic        re;
        logic [11:0] addr;
        logic        inv;
        logic [15:0] instr;
        logic [15:0] hits;
    } vec_t;
    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b1, 12'h102, 1'b0, 16'hABCD, 16'd1};
        vecs[1] = '{1'b1, 12'h100, 1'b0, 16'h1234, 16'd2};
        vecs[2] = '{1'b0, 12'h3FE, 1'b0, 16'h1234, 16'd2};
        vecs[3] = '{1'b1, 12'h101, 1'b0, 16'h1234, 16'd3};
        vecs[4] = '{1'b1, 12'h103, 1'b0, 16'hABCD, 16'd4};
        vecs[5] = '{1'b0, 12'h000, 1'b0, 16'hABCD, 16'd4};
        vecs[6] = '{1'b1, 12'h102, 1'b1, 16'hABCD, 16'd5};

        repeat (2) step();
        reset = 1'b0;
        repeat (2) step();
        check("rst_instr", 32'(instruction_out), 32'h1C00);
        check("rst_stall", 32'(stall_memory), 32'd0);
        check("rst_ce", 32'(sram_ce), 32'd0);
        check("rst_hits", 32'(perf_hits), 32'd0);
        check("rst_misses", 32'(perf_misses), 32'd0);

        miss(12'h100, 1'b0, 1'b0, 16'h1234, 16'd1);

        for (int i = 0; i < 7; i++) begin
            read_enable = vecs[i].re;
            address = vecs[i].addr;
            invalidate = vecs[i].inv;
            step();
            check($sformatf("vec%0d_instr", i), 32'(instruction_out), 32'(vecs[i].instr));
            check($sformatf("vec%0d_stall", i), 32'(stall_memory), 32'd0);
            check($sformatf("vec%0d_ce", i), 32'(sram_ce), 32'd0);
            check($sformatf("vec%0d_hits", i), 32'(perf_hits), 32'(vecs[i].hits));
            check($sformatf("vec%0d_misses", i), 32'(perf_misses), 32'd1);
        end
        read_enable = 1'b0;
        invalidate = 1'b0;

        miss(12'h100, 1'b1, 1'b0, 16'h1234, 16'd2);
        miss(12'h100, 1'b0, 1'b0, 16'h1234, 16'd3);
        miss(12'h202, 1'b0, 1'b1, mem(10'h080) >> 16, 16'd4);

        read_enable = 1'b1;
        address = 12'h100;
        step();
        check("rstmid_stall1", 32'(stall_memory), 32'd1);
        step();
        check("rstmid_stall2", 32'(stall_memory), 32'd1);
        reset = 1'b1;
        #1;
        check("rstmid_stall", 32'(stall_memory), 32'd0);
        check("rstmid_instr", 32'(instruction_out), 32'h1C00);
        check("rstmid_ce", 32'(sram_ce), 32'd0);
        check("rstmid_misses", 32'(perf_misses), 32'd0);
        read_enable = 1'b0;
        step();
        reset = 1'b0;
        step();
        miss(12'h100, 1'b0, 1'b0, 16'h1234, 16'd1);

        force dut.perf_hits = 16'hFFFE;
        #1;
        release dut.perf_hits;
        read_enable = 1'b1;
        address = 12'h102;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("sat_hits%0d", i), 32'(perf_hits), 32'h0000_FFFF);
            check($sformatf("sat_instr%0d", i), 32'(instruction_out), 32'h0000_ABCD);
        end
        read_enable = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
